// File: rtl/mux_tree_pipelined.sv
// Multi-lane select-or-zero mux tree, split into two registered stages with
// valid/ready flow control between the buffer read port and the PE array.

module mux_tree_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_IN     = 16,
  parameter int SEL_WIDTH  = $clog2(NUM_IN + 1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ld1,
  input  logic                               ld2,
  input  logic [NUM_IN-1:0][DATA_WIDTH-1:0]  vec,
  input  logic [SEL_WIDTH-1:0]               sel,
  output logic [DATA_WIDTH-1:0]              out,
  output logic                               out_is_zero
);
  localparam int NGRP = NUM_IN / 4;
  localparam int HW   = SEL_WIDTH - 2;

  typedef struct packed {
    logic                  zero;
    logic [DATA_WIDTH-1:0] data;
  } rsp_t;

  logic [NGRP-1:0][DATA_WIDTH-1:0] p1_d, p1;
  logic [HW-1:0]                   hi1;
  rsp_t                            rsp_d, rsp_q;

  // Stage 1: one 4:1 mux per group of four words, steered by the low select bits.
  always_comb begin
    p1_d = '0;
    for (int g = 0; g < NGRP; g++) begin
      for (int j = 0; j < 4; j++) begin
        if (sel[1:0] == 2'(j)) p1_d[g] = vec[4*g + j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1  <= '0;
      hi1 <= '0;
    end else if (ld1) begin
      p1  <= p1_d;
      hi1 <= sel[SEL_WIDTH-1:2];
    end
  end

  // Stage 2: pick the group; any high code past the last group forces zero.
  always_comb begin
    rsp_d.data = '0;
    rsp_d.zero = 1'b1;
    for (int g = 0; g < NGRP; g++) begin
      if (int'(hi1) == g) begin
        rsp_d.data = p1[g];
        rsp_d.zero = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_q <= '0;
    else if (ld2) rsp_q <= rsp_d;
  end

  assign out         = rsp_q.data;
  assign out_is_zero = rsp_q.zero;
endmodule

module mux_tree_pipelined #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_IN     = 16,
  parameter int NUM_LANE   = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_IN + 1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_IN-1:0][DATA_WIDTH-1:0]   vec,
  input  logic [NUM_LANE-1:0][SEL_WIDTH-1:0]  sel,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_LANE-1:0][DATA_WIDTH-1:0] out,
  output logic [NUM_LANE-1:0]                 out_is_zero
);
  generate
    if ((NUM_IN % 4) != 0 || NUM_IN < 4) begin : g_bad_num_in
      $error("mux_tree_pipelined: NUM_IN must be a multiple of 4 and >= 4");
    end
    if (NUM_LANE < 1) begin : g_bad_num_lane
      $error("mux_tree_pipelined: NUM_LANE must be >= 1");
    end
  endgenerate

  logic [2:1] vld_pipe;
  logic       adv1, adv2;

  // A stage may take new content when it is empty or its content moves on.
  assign adv2      = !vld_pipe[2] || out_ready;
  assign adv1      = !vld_pipe[1] || adv2;
  assign in_ready  = adv1;
  assign out_valid = vld_pipe[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (adv1) vld_pipe[1] <= in_valid;
      if (adv2) vld_pipe[2] <= vld_pipe[1];
    end
  end

  generate
    for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
      mux_tree_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_IN     (NUM_IN),
        .SEL_WIDTH  (SEL_WIDTH)
      ) u_lane (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld1         (adv1 && in_valid),
        .ld2         (adv2 && vld_pipe[1]),
        .vec         (vec),
        .sel         (sel[l]),
        .out         (out[l]),
        .out_is_zero (out_is_zero[l])
      );
    end
  endgenerate
endmodule

// File: tb/tb_mux_tree_pipelined.sv
// Bench for mux_tree_pipelined: directed scenarios on a 16-input instance and
// random valid/ready traffic on a 32-input instance against a queue model.

module tb_mux_tree_pipelined;
  localparam int A_IN = 16, A_DW = 8, A_LN = 4, A_SW = $clog2(A_IN + 1);
  localparam int B_IN = 32, B_DW = 4, B_LN = 4, B_SW = $clog2(B_IN + 1);

  logic clk, rst_n;

  logic                       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [A_IN-1:0][A_DW-1:0]  a_vec;
  logic [A_LN-1:0][A_SW-1:0]  a_sel;
  logic [A_LN-1:0][A_DW-1:0]  a_out;
  logic [A_LN-1:0]            a_out_is_zero;

  logic                       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [B_IN-1:0][B_DW-1:0]  b_vec;
  logic [B_LN-1:0][B_SW-1:0]  b_sel;
  logic [B_LN-1:0][B_DW-1:0]  b_out;
  logic [B_LN-1:0]            b_out_is_zero;

  int n_checks = 0;
  int n_fail   = 0;

  mux_tree_pipelined #(.DATA_WIDTH(A_DW), .NUM_IN(A_IN), .NUM_LANE(A_LN)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .vec(a_vec), .sel(a_sel), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out(a_out), .out_is_zero(a_out_is_zero)
  );

  mux_tree_pipelined #(.DATA_WIDTH(B_DW), .NUM_IN(B_IN), .NUM_LANE(B_LN)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .vec(b_vec), .sel(b_sel), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out(b_out), .out_is_zero(b_out_is_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference select rule: in-range code picks the word, anything else is zero.
  function automatic logic [A_DW-1:0] ref_a(input logic [A_IN-1:0][A_DW-1:0] v, input int s);
    return (s < A_IN) ? v[s] : '0;
  endfunction

  function automatic logic [B_DW-1:0] ref_b(input logic [B_IN-1:0][B_DW-1:0] v, input int s);
    return (s < B_IN) ? v[s] : '0;
  endfunction

  function automatic int pat(input int c, input int k);
    return (3*c + k) % A_IN;
  endfunction

  task automatic idle(input int n);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (a_out_valid !== 1'b0 || a_out !== '0 || a_out_is_zero !== '0) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b out=%h zero=%b, required 0/0/0", a_out_valid, a_out, a_out_is_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: a=%b b=%b, required 1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_full_range();
    for (int i = 0; i < A_IN; i++) a_vec[i] = 8'h10 + 8'(i);
    a_out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      a_in_valid = (c < 4);
      for (int k = 0; k < A_LN; k++) a_sel[k] = A_SW'(k + 4*(c % 4));
      #1;
      n_checks++;
      if (a_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL full_range_in_ready c=%0d: got %b, required 1", c, a_in_ready);
      end
      n_checks++;
      if (a_out_valid !== (c >= 2 && c <= 5)) begin
        n_fail++;
        $display("FAIL full_range_out_valid c=%0d: got %b, required %b", c, a_out_valid, (c >= 2 && c <= 5));
      end
      if (c >= 2 && c <= 5) begin
        for (int k = 0; k < A_LN; k++) begin
          n_checks++;
          if (a_out[k] !== ref_a(a_vec, k + 4*(c-2)) || a_out_is_zero[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL full_range_data c=%0d lane%0d: got %h/%b, required %h/0", c, k, a_out[k], a_out_is_zero[k], ref_a(a_vec, k + 4*(c-2)));
          end
        end
      end
    end
    idle(2);
  endtask

  task automatic test_zero_code();
    int s [A_LN];
    s[0] = 16; s[1] = 31; s[2] = 3; s[3] = 5;
    a_vec[3] = 8'h00;
    @(negedge clk);
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int k = 0; k < A_LN; k++) a_sel[k] = A_SW'(s[k]);
    @(negedge clk);
    a_in_valid = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (a_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_code_valid: got %b, required 1", a_out_valid);
    end
    for (int k = 0; k < A_LN; k++) begin
      n_checks++;
      if (a_out[k] !== ref_a(a_vec, s[k]) || a_out_is_zero[k] !== (s[k] >= A_IN)) begin
        n_fail++;
        $display("FAIL zero_code lane%0d sel=%0d: got %h/%b, required %h/%b", k, s[k], a_out[k], a_out_is_zero[k], ref_a(a_vec, s[k]), (s[k] >= A_IN));
      end
    end
    a_vec[3] = 8'h13;
    idle(2);
  endtask

  task automatic test_backpressure();
    logic [A_LN-1:0][A_DW-1:0] exp;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      a_in_valid  = (c < 5);
      a_out_ready = (c >= 5);
      for (int k = 0; k < A_LN; k++) a_sel[k] = A_SW'(pat(c, k));
      #1;
      n_checks++;
      if (a_in_ready !== (c < 2 || c >= 5)) begin
        n_fail++;
        $display("FAIL backpressure_in_ready c=%0d: got %b, required %b", c, a_in_ready, (c < 2 || c >= 5));
      end
      n_checks++;
      if (a_out_valid !== (c >= 2 && c <= 6)) begin
        n_fail++;
        $display("FAIL backpressure_out_valid c=%0d: got %b, required %b", c, a_out_valid, (c >= 2 && c <= 6));
      end
      if (c >= 2 && c <= 6) begin
        for (int k = 0; k < A_LN; k++) exp[k] = ref_a(a_vec, pat((c == 6) ? 1 : 0, k));
        n_checks++;
        if (a_out !== exp) begin
          n_fail++;
          $display("FAIL backpressure_data c=%0d: got %h, required %h", c, a_out, exp);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_reset_midstream();
    a_out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      for (int k = 0; k < A_LN; k++) a_sel[k] = A_SW'(pat(c + 4, k));
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    n_checks++;
    if (a_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midstream_prefill: out_valid=%b, required 1", a_out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_out_valid !== 1'b0 || a_out !== '0 || a_out_is_zero !== '0) begin
      n_fail++;
      $display("FAIL midstream_async_clear: out_valid=%b out=%h zero=%b, required 0/0/0", a_out_valid, a_out, a_out_is_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midstream_in_ready: got %b, required 1", a_in_ready);
    end
    a_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (a_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midstream_stale c=%0d: out_valid=%b, required 0", c, a_out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [B_LN-1:0][B_DW-1:0] q_data [$];
    logic [B_LN-1:0]           q_zero [$];
    logic [B_LN-1:0][B_DW-1:0] e_data, h_data;
    logic [B_LN-1:0]           e_zero, h_zero;
    logic                      ir;
    int got = 0;
    int cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      for (int i = 0; i < B_IN; i++) b_vec[i] = B_DW'($urandom);
      for (int k = 0; k < B_LN; k++) b_sel[k] = B_SW'($urandom_range(0, 40));
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      ir = b_in_ready;
      b_in_valid = !b_in_valid;
      #1;
      n_checks++;
      if (b_in_ready !== ir) begin
        n_fail++;
        $display("FAIL random_in_ready_indep cyc=%0d: got %b, required %b", cyc, b_in_ready, ir);
      end
      b_in_valid = !b_in_valid;
      #1;
      if (b_out_valid && b_out_ready) begin
        n_checks++;
        if (q_data.size() == 0) begin
          n_fail++;
          $display("FAIL random_spurious cyc=%0d: out=%h with no expected result", cyc, b_out);
        end else begin
          h_data = q_data.pop_front();
          h_zero = q_zero.pop_front();
          if (b_out !== h_data || b_out_is_zero !== h_zero) begin
            n_fail++;
            $display("FAIL random_data beat=%0d: got %h/%b, required %h/%b", got, b_out, b_out_is_zero, h_data, h_zero);
          end
        end
        got++;
      end
      if (b_in_valid && b_in_ready) begin
        for (int k = 0; k < B_LN; k++) begin
          e_data[k] = ref_b(b_vec, int'(b_sel[k]));
          e_zero[k] = (int'(b_sel[k]) >= B_IN);
        end
        q_data.push_back(e_data);
        q_zero.push_back(e_zero);
      end
      cyc++;
    end
    n_checks++;
    if (got < 1000) begin
      n_fail++;
      $display("FAIL random_timeout: got %0d results, required 1000", got);
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (b_out_valid) begin
        n_checks++;
        if (q_data.size() == 0) begin
          n_fail++;
          $display("FAIL random_drain_spurious: out=%h", b_out);
        end else begin
          h_data = q_data.pop_front();
          h_zero = q_zero.pop_front();
          if (b_out !== h_data || b_out_is_zero !== h_zero) begin
            n_fail++;
            $display("FAIL random_drain_data: got %h/%b, required %h/%b", b_out, b_out_is_zero, h_data, h_zero);
          end
        end
      end
    end
    n_checks++;
    if (q_data.size() != 0) begin
      n_fail++;
      $display("FAIL random_lost: %0d results never emerged, required 0", q_data.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_vec = '0; a_sel = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_vec = '0; b_sel = '0;
    test_reset();
    test_full_range();
    test_zero_code();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
